// File: rtl/risc_spm_pkg.sv
// risc_spm_pkg
// Declarations shared by the ALU files:
//   - default datapath and opcode widths;
//   - opcode encodings (the legacy set plus the new ALU ops);
//   - the ALU handshake state type.
// Ports: none (package).
package risc_spm_pkg;

  localparam int WORD_SIZE = 8;
  localparam int OP_SIZE   = 4;

  // Legacy encodings, unchanged from the combinational ALU
  localparam logic [3:0] OPC_NOP = 4'b0000;
  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_AND = 4'b0011;
  localparam logic [3:0] OPC_NOT = 4'b0100;

  // New ALU opcodes
  localparam logic [3:0] OPC_MUL = 4'b1001;
  localparam logic [3:0] OPC_OR  = 4'b1010;
  localparam logic [3:0] OPC_XOR = 4'b1011;
  localparam logic [3:0] OPC_SHL = 4'b1100;
  localparam logic [3:0] OPC_SHR = 4'b1101;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_risc_mul_seq.sv
// alu_risc_mul_seq
// Shift-and-add unsigned multiplier: one partial product per clock, word_size steps.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   load                 capture operands, clear accumulator and step counter
//   run                  advance one shift-add step this cycle
//   multiplicand         first operand (captured on load)
//   multiplier           second operand (captured on load)
//   product   [2W-1:0]   accumulator value after this cycle's step (combinational)
//   ready                high during the final step; product is complete this cycle
import risc_spm_pkg::*;

module alu_risc_mul_seq #(
  parameter int word_size = WORD_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     run,
  input  logic [word_size-1:0]     multiplicand,
  input  logic [word_size-1:0]     multiplier,
  output logic [2*word_size-1:0]   product,
  output logic                     ready
);

  localparam int CW = $clog2(word_size);

  logic [2*word_size-1:0] acc;
  logic [2*word_size-1:0] mcand;
  logic [2*word_size-1:0] acc_next;
  logic [word_size-1:0]   mplier;
  logic [CW-1:0]          step_cnt;

  // The multiplier is shifted right so bit 0 always selects the current
  // partial product; the multiplicand is shifted left to keep alignment.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // Exposing the post-step sum lets the parent register the final product
  // on the same edge as the last step, with no extra cycle.
  assign product = acc_next;
  assign ready   = run && (step_cnt == CW'(word_size - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      step_cnt <= '0;
    end else if (load) begin
      acc      <= '0;
      mcand    <= {{word_size{1'b0}}, multiplicand};
      mplier   <= multiplier;
      step_cnt <= '0;
    end else if (run) begin
      acc      <= acc_next;
      mcand    <= mcand << 1;
      mplier   <= mplier >> 1;
      step_cnt <= step_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_risc_mc.sv
// alu_risc_mc
// Registered multi-cycle ALU with a start/busy/done handshake. Single-cycle ops
// complete on the edge that samples start. MUL runs word_size shift-add steps.
// Optional feature macro: ALU_RISC_MC_MUL_EN
//   - defined: the sequential multiplier is built.
//   - undefined: MUL behaves as an undefined opcode.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   start, sel, data_1, data_2     request strobe, opcode, operands (sampled when not busy)
//   alu_out, alu_out_hi            result word, MUL high word (0 for other ops)
//   alu_zero/carry/neg/ovf_flag    registered status flags
//   busy, done                     multiply in progress, one-cycle completion pulse
import risc_spm_pkg::*;

module alu_risc_mc #(
  parameter int                 word_size = WORD_SIZE,
  parameter int                 op_size   = OP_SIZE,
  parameter logic [op_size-1:0] NOP       = op_size'(OPC_NOP),
  parameter logic [op_size-1:0] ADD       = op_size'(OPC_ADD),
  parameter logic [op_size-1:0] SUB       = op_size'(OPC_SUB),
  parameter logic [op_size-1:0] AND       = op_size'(OPC_AND),
  parameter logic [op_size-1:0] NOT       = op_size'(OPC_NOT),
  parameter logic [op_size-1:0] MUL       = op_size'(OPC_MUL),
  parameter logic [op_size-1:0] OR        = op_size'(OPC_OR),
  parameter logic [op_size-1:0] XOR       = op_size'(OPC_XOR),
  parameter logic [op_size-1:0] SHL       = op_size'(OPC_SHL),
  parameter logic [op_size-1:0] SHR       = op_size'(OPC_SHR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [op_size-1:0]   sel,
  input  logic [word_size-1:0] data_1,
  input  logic [word_size-1:0] data_2,
  output logic [word_size-1:0] alu_out,
  output logic [word_size-1:0] alu_out_hi,
  output logic                 alu_zero_flag,
  output logic                 alu_carry_flag,
  output logic                 alu_neg_flag,
  output logic                 alu_ovf_flag,
  output logic                 busy,
  output logic                 done
);

  localparam int MSB = word_size - 1;

  logic [word_size:0]   add_w;
  logic [word_size:0]   sub_w;
  logic [word_size-1:0] op_res;
  logic                 op_carry;
  logic                 op_ovf;
  logic                 fire_single;
  logic                 mul_finish;
  logic [word_size-1:0] mul_lo;
  logic                 mul_zero;

  // One extra bit on the adder/subtractor gives carry out and, for
  // data_2 - data_1, a set top bit exactly when data_2 < data_1 (borrow).
  assign add_w = {1'b0, data_1} + {1'b0, data_2};
  assign sub_w = {1'b0, data_2} - {1'b0, data_1};

  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    case (sel)
      ADD: begin
        op_res   = add_w[MSB:0];
        op_carry = add_w[word_size];
        op_ovf   = (data_1[MSB] == data_2[MSB]) && (op_res[MSB] != data_1[MSB]);
      end
      SUB: begin
        op_res   = sub_w[MSB:0];
        op_carry = sub_w[word_size];
        op_ovf   = (data_1[MSB] != data_2[MSB]) && (op_res[MSB] != data_2[MSB]);
      end
      AND: op_res = data_1 & data_2;
      OR:  op_res = data_1 | data_2;
      XOR: op_res = data_1 ^ data_2;
      NOT: op_res = ~data_2;
      SHL: begin
        op_res   = data_2 << 1;
        op_carry = data_2[MSB];
      end
      SHR: begin
        op_res   = data_2 >> 1;
        op_carry = data_2[0];
      end
      // MUL never completes through this path when the multiplier is built;
      // without it, MUL yields 0 like NOP and undefined opcodes.
      MUL:     op_res = '0;
      default: op_res = '0;
    endcase
  end

`ifdef ALU_RISC_MC_MUL_EN
  alu_state_e             state;
  alu_state_e             state_next;
  logic                   mul_load;
  logic                   mul_ready;
  logic [2*word_size-1:0] mul_product;
  logic [word_size-1:0]   hi_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && (sel == MUL)) state_next = MUL_RUN;
      MUL_RUN: if (mul_ready)             state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // start is only honoured in IDLE, so a strobe during MUL_RUN is dropped.
  always_comb begin
    busy        = 1'b0;
    mul_load    = 1'b0;
    fire_single = 1'b0;
    case (state)
      IDLE: begin
        mul_load    = start && (sel == MUL);
        fire_single = start && (sel != MUL);
      end
      MUL_RUN: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  alu_risc_mul_seq #(.word_size(word_size)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .load         (mul_load),
    .run          (busy),
    .multiplicand (data_1),
    .multiplier   (data_2),
    .product      (mul_product),
    .ready        (mul_ready)
  );

  assign mul_finish = mul_ready;
  assign mul_lo     = mul_product[MSB:0];
  assign mul_zero   = (mul_product == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             hi_q <= '0;
    else if (fire_single) hi_q <= '0;
    else if (mul_finish)  hi_q <= mul_product[2*word_size-1:word_size];
  end

  assign alu_out_hi = hi_q;
`else
  assign busy        = 1'b0;
  assign fire_single = start;
  assign mul_finish  = 1'b0;
  assign mul_lo      = '0;
  assign mul_zero    = 1'b0;
  assign alu_out_hi  = '0;
`endif

  // Result and flags only change on a completion; otherwise they hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out        <= '0;
      alu_zero_flag  <= 1'b0;
      alu_carry_flag <= 1'b0;
      alu_neg_flag   <= 1'b0;
      alu_ovf_flag   <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= fire_single | mul_finish;
      if (fire_single) begin
        alu_out        <= op_res;
        alu_zero_flag  <= (op_res == '0);
        alu_carry_flag <= op_carry;
        alu_neg_flag   <= op_res[MSB];
        alu_ovf_flag   <= op_ovf;
      end else if (mul_finish) begin
        alu_out        <= mul_lo;
        alu_zero_flag  <= mul_zero;
        alu_carry_flag <= 1'b0;
        alu_neg_flag   <= mul_lo[MSB];
        alu_ovf_flag   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_risc_mc.sv
// tb_alu_risc_mc
// Self-checking bench for alu_risc_mc at word_size=8. Expected results come from
// an arithmetic model and travel through a scoreboard queue until done.
// Honours ALU_RISC_MC_MUL_EN for the expected MUL behaviour.
module tb_alu_risc_mc;

  localparam int W = 8;
  localparam logic [3:0] OP_NOP = 4'b0000, OP_ADD = 4'b0001, OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011, OP_NOT = 4'b0100, OP_MUL = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1010, OP_XOR = 4'b1011, OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
`ifdef ALU_RISC_MC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] sel;
  logic [7:0] data_1, data_2;
  logic [7:0] alu_out, alu_out_hi;
  logic       alu_zero_flag, alu_carry_flag, alu_neg_flag, alu_ovf_flag;
  logic       busy, done;

  int errors = 0;
  int checks = 0;

  // Scoreboard: packed {alu_out, alu_out_hi, zero, carry, neg, ovf} and latency
  logic [19:0] sb_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  alu_risc_mc #(.word_size(W), .op_size(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .sel            (sel),
    .data_1         (data_1),
    .data_2         (data_2),
    .alu_out        (alu_out),
    .alu_out_hi     (alu_out_hi),
    .alu_zero_flag  (alu_zero_flag),
    .alu_carry_flag (alu_carry_flag),
    .alu_neg_flag   (alu_neg_flag),
    .alu_ovf_flag   (alu_ovf_flag),
    .busy           (busy),
    .done           (done)
  );

  // Integer reference model of every opcode.
  function automatic logic [19:0] model(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    int ua, ub, ia, ib, r, p;
    logic [7:0] lo, hi;
    logic z, c, v;
    ua = int'(a); ub = int'(b);
    ia = (ua > 127) ? ua - 256 : ua;
    ib = (ub > 127) ? ub - 256 : ub;
    lo = 8'h00; hi = 8'h00; c = 1'b0; v = 1'b0; p = 0;
    case (op)
      OP_ADD: begin
        r = ua + ub; lo = 8'(r % 256); c = (r > 255);
        v = ((ia + ib) > 127) || ((ia + ib) < -128);
      end
      OP_SUB: begin
        r = ub - ua; lo = 8'((r + 256) % 256); c = (r < 0);
        v = ((ib - ia) > 127) || ((ib - ia) < -128);
      end
      OP_AND: lo = a & b;
      OP_OR:  lo = a | b;
      OP_XOR: lo = a ^ b;
      OP_NOT: lo = ~b;
      OP_SHL: begin lo = 8'((ub * 2) % 256); c = (ub >= 128); end
      OP_SHR: begin lo = 8'(ub / 2); c = (ub % 2) == 1; end
      OP_MUL: if (MUL_ON) begin
        p = ua * ub; lo = 8'(p % 256); hi = 8'(p / 256);
      end
      default: lo = 8'h00;
    endcase
    z = (op == OP_MUL && MUL_ON) ? (p == 0) : (lo == 8'h00);
    return {lo, hi, z, c, lo[7], v};
  endfunction

  function automatic logic [19:0] observed();
    return {alu_out, alu_out_hi, alu_zero_flag, alu_carry_flag, alu_neg_flag, alu_ovf_flag};
  endfunction

  // Drive one start strobe at a falling edge and record what should come back.
  task automatic drive_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; sel = op; data_1 = a; data_2 = b;
    sb_q.push_back(model(op, a, b));
    lat_q.push_back((op == OP_MUL && MUL_ON) ? W : 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done, bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; sel = OP_NOP; data_1 = 8'h00; data_2 = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (observed() !== 20'h0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h want %h", observed(), 20'h0);
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_handshake: got %b want 00", {busy, done});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle_done: got %b want 0", done);
    end
  endtask

  task automatic test_add();
    logic [19:0] tbl [3] = '{{OP_ADD, 8'hFF, 8'h01}, {OP_ADD, 8'h7F, 8'h01},
                            {OP_ADD, 8'h80, 8'h80}};
    logic [3:0] op; logic [7:0] a, b; logic [19:0] exp; int cyc, lat;
    for (int i = 0; i < 3; i++) begin
      {op, a, b} = tbl[i];
      drive_op(op, a, b);
      wait_done(cyc);
      exp = sb_q.pop_front(); lat = lat_q.pop_front();
      checks++;
      if (cyc !== lat) begin
        errors++; $display("[TB] FAIL add_latency[%0d]: got %0d want %0d", i, cyc, lat);
      end
      checks++;
      if (observed() !== exp) begin
        errors++; $display("[TB] FAIL add_result[%0d]: got %h want %h", i, observed(), exp);
      end
    end
  endtask

  task automatic test_sub();
    logic [19:0] tbl [4] = '{{OP_SUB, 8'h05, 8'h03}, {OP_SUB, 8'h03, 8'h05},
                            {OP_SUB, 8'h80, 8'h00}, {OP_SUB, 8'h7F, 8'h7F}};
    logic [3:0] op; logic [7:0] a, b; logic [19:0] exp; int cyc, lat;
    for (int i = 0; i < 4; i++) begin
      {op, a, b} = tbl[i];
      drive_op(op, a, b);
      wait_done(cyc);
      exp = sb_q.pop_front(); lat = lat_q.pop_front();
      checks++;
      if (cyc !== lat || observed() !== exp) begin
        errors++;
        $display("[TB] FAIL sub[%0d]: got %h after %0d cycles want %h after %0d", i,
                 observed(), cyc, exp, lat);
      end
    end
  endtask

  task automatic test_logic();
    logic [19:0] tbl [8] = '{{OP_AND, 8'hF0, 8'h3C}, {OP_OR, 8'hA0, 8'h05},
                            {OP_XOR, 8'hFF, 8'h0F}, {OP_NOT, 8'h12, 8'hFF},
                            {OP_SHL, 8'h00, 8'h81}, {OP_SHR, 8'h00, 8'h03},
                            {OP_NOP, 8'hAA, 8'h55}, {4'b1111, 8'h01, 8'h02}};
    logic [3:0] op; logic [7:0] a, b; logic [19:0] exp; int cyc, lat;
    for (int i = 0; i < 8; i++) begin
      {op, a, b} = tbl[i];
      drive_op(op, a, b);
      wait_done(cyc);
      exp = sb_q.pop_front(); lat = lat_q.pop_front();
      checks++;
      if (cyc !== lat || observed() !== exp) begin
        errors++;
        $display("[TB] FAIL logic[%0d] op=%b: got %h after %0d want %h after %0d", i, op,
                 observed(), cyc, exp, lat);
      end
    end
  endtask

  task automatic test_mul();
    logic [19:0] tbl [2] = '{{OP_MUL, 8'hFF, 8'hFF}, {OP_MUL, 8'h0F, 8'h11}};
    logic [3:0] op; logic [7:0] a, b; logic [19:0] exp; int cyc, w, lat;
    for (int i = 0; i < 2; i++) begin
      {op, a, b} = tbl[i];
      drive_op(op, a, b);
      cyc = 0;
`ifdef ALU_RISC_MC_MUL_EN
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("[TB] FAIL mul_busy[%0d]: got %b want 1", i, busy);
      end
      // This strobe lands while busy and must be dropped; the operand change
      // must not disturb the product in flight.
      start = 1'b1; sel = OP_ADD; data_1 = 8'h01; data_2 = 8'h01;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
`endif
      wait_done(w);
      cyc += w;
      exp = sb_q.pop_front(); lat = lat_q.pop_front();
      checks++;
      if (cyc !== lat) begin
        errors++; $display("[TB] FAIL mul_latency[%0d]: got %0d want %0d", i, cyc, lat);
      end
      checks++;
      if (observed() !== exp) begin
        errors++; $display("[TB] FAIL mul_result[%0d]: got %h want %h", i, observed(), exp);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("[TB] FAIL mul_busy_clear[%0d]: got %b want 0", i, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("[TB] FAIL mul_done_pulse[%0d]: got %b want 0", i, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] tbl [4] = '{{OP_ADD, 8'h10, 8'h20}, {OP_SUB, 8'h01, 8'h00},
                            {OP_XOR, 8'h5A, 8'h5A}, {OP_SHL, 8'h00, 8'h40}};
    logic [3:0] op; logic [7:0] a, b; logic [19:0] exp;
    {op, a, b} = tbl[0];
    start = 1'b1; sel = op; data_1 = a; data_2 = b;
    sb_q.push_back(model(op, a, b));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      checks++;
      if (done !== 1'b1 || observed() !== exp) begin
        errors++;
        $display("[TB] FAIL b2b[%0d]: done=%b got %h want done=1 %h", i, done, observed(), exp);
      end
      if (i < 3) begin
        {op, a, b} = tbl[i + 1];
        sel = op; data_1 = a; data_2 = b;
        sb_q.push_back(model(op, a, b));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_done_drop: got %b want 0", done);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [19:0] exp; int cyc, lat, extra_done;
    drive_op(OP_ADD, 8'h40, 8'h41);
    wait_done(cyc);
    exp = sb_q.pop_front(); lat = lat_q.pop_front();
    checks++;
    if (cyc !== lat || observed() !== exp) begin
      errors++; $display("[TB] FAIL pre_reset_add: got %h want %h", observed(), exp);
    end
    drive_op(OP_MUL, 8'hFF, 8'hFF);
`ifdef ALU_RISC_MC_MUL_EN
    repeat (3) @(negedge clk);
`endif
    sb_q.delete(); lat_q.delete();
    rst = 1'b0;
    #1;
    checks++;
    if ({observed(), busy, done} !== 22'h0) begin
      errors++; $display("[TB] FAIL mid_reset_outputs: got %h want 0", {observed(), busy, done});
    end
    @(negedge clk);
    rst = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done !== 0) begin
      errors++; $display("[TB] FAIL mid_reset_no_done: got %0d pulses want 0", extra_done);
    end
    drive_op(OP_ADD, 8'h02, 8'h03);
    wait_done(cyc);
    exp = sb_q.pop_front(); lat = lat_q.pop_front();
    checks++;
    if (cyc !== lat || observed() !== exp) begin
      errors++;
      $display("[TB] FAIL post_reset_add: got %h after %0d want %h after %0d", observed(), cyc,
               exp, lat);
    end
  endtask

  task automatic test_random();
    logic [3:0] op; logic [7:0] a, b; logic [19:0] exp; int cyc, lat;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      drive_op(op, a, b);
      wait_done(cyc);
      exp = sb_q.pop_front(); lat = lat_q.pop_front();
      checks++;
      if (cyc !== lat || observed() !== exp) begin
        errors++;
        $display("[TB] FAIL random[%0d] op=%b a=%h b=%h: got %h after %0d want %h after %0d",
                 i, op, a, b, observed(), cyc, exp, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_risc_mc.md
# alu_risc_mc

Multi-cycle, registered successor to the combinational datapath ALU. Accepts an operation on a start strobe, produces a registered result and a registered flag set (zero, carry/borrow, negative, overflow), and adds a shift-and-add multiplier that takes `word_size` cycles. It sits between Reg_Y/Bus_1 and the result register and is sequenced by the control unit through a start/busy/done handshake.

## Interface

**Parameters**
- `word_size`, default 8: datapath width in bits; minimum 2.
- `op_size`, default 4: opcode width.
- `NOP`, `ADD`, `SUB`, `AND`, `NOT`: 0000, 0001, 0010, 0011, 0100; encodings unchanged from the existing ALU.
- `MUL`, `OR`, `XOR`, `SHL`, `SHR`: 1001, 1010, 1011, 1100, 1101; new ALU opcodes.

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe; sampled only when `busy`=0.
- `sel` in `op_size`: opcode, sampled with `start`.
- `data_1` in `word_size`: Reg_Y operand, sampled with `start`.
- `data_2` in `word_size`: Bus_1 operand, sampled with `start`.
- `alu_out` out `word_size`: result (MUL: low word).
- `alu_out_hi` out `word_size`: MUL high word; 0 for all other ops.
- `alu_zero_flag` out 1: result is zero.
- `alu_carry_flag` out 1: carry or borrow.
- `alu_neg_flag` out 1: MSB of `alu_out`.
- `alu_ovf_flag` out 1: signed overflow.
- `busy` out 1: multi-cycle operation in progress.
- `done` out 1: one-cycle pulse; result and flags updated this cycle.

## Operation

**States:** IDLE, MUL_RUN.

- **IDLE** with `start`=1:
  - Single-cycle op: compute and write results/flags at that edge, pulse `done`, stay in IDLE.
  - MUL: load multiplicand=`data_1`, multiplier=`data_2`, and accumulator=0. Step counter=0, `busy`=1, go to MUL_RUN.
- **MUL_RUN:** one shift-add step per edge. At the `word_size`-th step:
  - write `{alu_out_hi,alu_out}` with the 2W product;
  - set `busy`=0, pulse `done`, return to IDLE.
- `start` while `busy`=1 is ignored. It is neither queued nor errored.
- `start` in the same cycle as `done`:
  - Legal, because `busy` is already 0.
  - Back-to-back single-cycle ops therefore give one result per cycle.
- **Results.** All arithmetic is modulo 2^W.
  - ADD: `data_1`+`data_2`.
  - SUB: `data_2`−`data_1`.
  - AND, OR, XOR: bitwise on the two operands.
  - NOT: ~`data_2`.
  - SHL: `data_2`<<1.
  - SHR: `data_2`>>1, logical.
  - MUL: unsigned 2W product.
  - NOP and undefined opcodes: 0.
- **Carry flag:**
  - ADD: carry out of bit W−1.
  - SUB: borrow, i.e. `data_2`<`data_1` unsigned.
  - SHL: bit W−1 of `data_2`.
  - SHR: bit 0 of `data_2`.
  - All other ops: 0.
- **Overflow flag:**
  - ADD: operands share a sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from `data_2`'s sign.
  - All other ops: 0.
- **Zero flag:**
  - MUL: `{alu_out_hi,alu_out}`==0.
  - All other ops: `alu_out`==0.
- Outputs and flags hold their values between `done` pulses.

## Timing

- **Reset values:** all outputs 0, state IDLE, counter 0.
- **Reset mid-MUL:** aborts immediately. Outputs return to reset values and no `done` is issued.
- **Single-cycle latency:** `start` sampled at edge N → results valid and `done`=1 during the cycle after edge N.
- **MUL latency:** `start` at edge N → `busy`=1 after edges N..N+W−1 → product written at edge N+W. `done`=1 and `busy`=0 in the cycle after N+W.
- `done` is never high for more than one consecutive cycle unless a new `start` is accepted.
- Operand and `sel` changes after acceptance have no effect on an in-flight MUL.

## Configuration

- `ALU_RISC_MC_MUL_EN` defined:
  - MUL_RUN state, step counter and shift-add datapath are present, with behaviour as above.
- `ALU_RISC_MC_MUL_EN` undefined:
  - MUL decodes as an undefined opcode: single-cycle, result 0, `alu_zero_flag`=1.
  - `busy` is tied to 0 and `alu_out_hi` is tied to 0.
  - No multiplier logic is synthesised.

## Structure

- **Shared package `risc_spm_pkg`:**
  - opcode constants, covering both the existing encodings and the new ones;
  - the state enum {IDLE, MUL_RUN};
  - the default `word_size`.
- **Sub-module `alu_risc_mul_seq`:** holds the shift-add multiplier (counter, accumulator, ready pulse).
  - The top level holds the combinational op decode, the flag logic and the handshake FSM.

## Test plan

All scenarios use W=8.

- **ADD with carry:** reset, then ADD `data_1`=0xFF, `data_2`=0x01 → one cycle later `done`=1, `alu_out`=0x00, zero=1, carry=1, ovf=0.
- **ADD with overflow:** ADD 0x7F+0x01 → `alu_out`=0x80, neg=1, ovf=1, carry=0.
- **SUB with borrow:** SUB `data_1`=0x05, `data_2`=0x03 → `alu_out`=0xFE, carry (borrow)=1, neg=1, zero=0.
- **MUL, full-width operands:** MUL 0xFF×0xFF → `busy`=1 for 8 cycles, then `done` with `alu_out_hi`=0xFE and `alu_out`=0x01. An ADD `start` pulsed mid-operation is ignored.
- **MUL, small product:** MUL 0x0F×0x11 → hi=0x00, lo=0xFF.
- **Reset mid-MUL:** drop `rst` at step 4 → all outputs 0 immediately and no `done` pulse. A following ADD 0x02+0x03 → 0x05 in one cycle.
